// File: rtl/fft_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_seq_pkg
//  Description : Shared types, widths and helpers for the FFT frame sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET_FFT = 3'd1,
        LOAD      = 3'd2,
        WAIT_FFT  = 3'd3,
        DRAIN     = 3'd4
    } seq_state_t;

    localparam int ADC_W     = 12;
    localparam int DATA_W    = 16;
    localparam int ADC_SHIFT = 4;

    // Bits needed to index n items; never returns zero.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that either saturates at all-ones or wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic             w_hold;

    generate
        if (SATURATE) begin : g_saturate
            assign w_hold = &r_count;
        end else begin : g_wrap
            assign w_hold = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (inc && !w_hold) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_sequencer
//  Description : Frames the ADC stream into the FFT core and forwards the
//                non-mirrored half of the magnitude spectrum with bin tags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int FFT_LENGTH = 1024,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic [ADC_W-1:0]                  adc_data,
    input  logic                              adc_data_valid,
    input  logic                              done_FFT,
    input  logic [DATA_W-1:0]                 magnitude,
    input  logic                              magnitude_ready,
    output logic                              fft_reset,
    output logic                              fft_stream_active,
    output logic [DATA_W-1:0]                 fft_input_real,
    output logic [DATA_W-1:0]                 mag_out,
    output logic [idx_width(FFT_LENGTH)-2:0]  mag_bin,
    output logic                              mag_valid,
    output logic                              frame_done,
    output logic [15:0]                       frame_count,
    output logic [15:0]                       drop_count,
    output logic                              timeout_err
);

    localparam int c_idx_w = idx_width(FFT_LENGTH);
    localparam int c_bin_w = c_idx_w - 1;
    localparam int c_rst_w = idx_width(RST_CYCLES);
    localparam int c_to_w  = idx_width(TIMEOUT + 1);

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(FFT_LENGTH - 1);
    localparam logic [c_rst_w-1:0] c_last_rst = c_rst_w'(RST_CYCLES - 1);
    localparam logic [c_to_w-1:0]  c_timeout  = c_to_w'(TIMEOUT);

    seq_state_t r_state, w_next_state;

    logic [c_idx_w-1:0] r_sample_cnt;
    logic [c_idx_w-1:0] r_bin_cnt;
    logic [c_rst_w-1:0] r_rst_cnt;
    logic [c_to_w-1:0]  r_to_cnt;
    logic               r_stop;

    logic               r_fft_reset;
    logic               r_stream_active;
    logic [DATA_W-1:0]  r_input_real;
    logic [DATA_W-1:0]  r_mag_out;
    logic [c_bin_w-1:0] r_mag_bin;
    logic               r_mag_valid;
    logic               r_frame_done;
    logic               r_timeout_err;

    logic w_load_accept;
    logic w_last_sample;
    logic w_timeout;
    logic w_drain_strobe;
    logic w_last_bin;
    logic w_lower_half;
    logic w_continue;
    logic w_drop;

    assign w_load_accept  = (r_state == LOAD) && adc_data_valid;
    assign w_last_sample  = w_load_accept && (r_sample_cnt == c_last_idx);
    assign w_timeout      = (r_state == WAIT_FFT) && !done_FFT && (r_to_cnt == c_timeout);
    assign w_drain_strobe = (r_state == DRAIN) && magnitude_ready;
    assign w_last_bin     = w_drain_strobe && (r_bin_cnt == c_last_idx);
    assign w_lower_half   = !r_bin_cnt[c_idx_w-1];
    // Once enable drops inside a frame, the frame still finishes but no new one starts.
    assign w_continue     = enable && !r_stop;
    assign w_drop         = adc_data_valid && (r_state != LOAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (enable) w_next_state = RESET_FFT;
            RESET_FFT: if (r_rst_cnt == c_last_rst) w_next_state = LOAD;
            LOAD:      if (w_last_sample) w_next_state = WAIT_FFT;
            WAIT_FFT: begin
                if (done_FFT) begin
                    w_next_state = DRAIN;
                end else if (w_timeout) begin
                    w_next_state = w_continue ? RESET_FFT : IDLE;
                end
            end
            DRAIN:     if (w_last_bin) w_next_state = w_continue ? RESET_FFT : IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // Each counter is held at zero outside its own state, so entry always starts fresh.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_cnt    <= '0;
            r_sample_cnt <= '0;
            r_to_cnt     <= '0;
            r_bin_cnt    <= '0;
            r_stop       <= 1'b0;
        end else begin
            r_rst_cnt    <= (r_state == RESET_FFT) ? r_rst_cnt + 1'b1 : '0;
            if (r_state != LOAD) begin
                r_sample_cnt <= '0;
            end else if (adc_data_valid) begin
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end
            if (r_state != WAIT_FFT) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != c_timeout) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (r_state != DRAIN) begin
                r_bin_cnt <= '0;
            end else if (magnitude_ready) begin
                r_bin_cnt <= r_bin_cnt + 1'b1;
            end
            if (r_state == IDLE) begin
                r_stop <= 1'b0;
            end else if (!enable) begin
                r_stop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fft_reset     <= 1'b1;
            r_stream_active <= 1'b0;
            r_input_real    <= '0;
            r_mag_out       <= '0;
            r_mag_bin       <= '0;
            r_mag_valid     <= 1'b0;
            r_frame_done    <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_fft_reset     <= (w_next_state == IDLE) || (w_next_state == RESET_FFT);
            r_stream_active <= w_load_accept;
            if (w_load_accept) begin
                r_input_real <= {adc_data, {ADC_SHIFT{1'b0}}};
            end
            r_mag_valid     <= w_drain_strobe && w_lower_half;
            if (w_drain_strobe && w_lower_half) begin
                r_mag_out <= magnitude;
                r_mag_bin <= r_bin_cnt[c_bin_w-1:0];
            end
            r_frame_done    <= w_last_bin;
            r_timeout_err   <= r_timeout_err | w_timeout;
        end
    end

    sat_counter #(
        .WIDTH    (16),
        .SATURATE (1'b1)
    ) u_drop_count (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_drop),
        .count   (drop_count)
    );

    sat_counter #(
        .WIDTH    (16),
        .SATURATE (1'b0)
    ) u_frame_count (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_last_bin),
        .count   (frame_count)
    );

    assign fft_reset         = r_fft_reset;
    assign fft_stream_active = r_stream_active;
    assign fft_input_real    = r_input_real;
    assign mag_out           = r_mag_out;
    assign mag_bin           = r_mag_bin;
    assign mag_valid         = r_mag_valid;
    assign frame_done        = r_frame_done;
    assign timeout_err       = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_frame_sequencer
//  Description : Directed self-checking bench for fft_frame_sequencer
//                (16-point frames, 4 reset cycles, timeout of 100).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_sequencer;

    localparam int N    = 16;
    localparam int HALF = N / 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] adc_data = '0;
    logic        adc_data_valid = 1'b0;
    logic        done_FFT = 1'b0;
    logic [15:0] magnitude = '0;
    logic        magnitude_ready = 1'b0;
    logic        fft_reset;
    logic        fft_stream_active;
    logic [15:0] fft_input_real;
    logic [15:0] mag_out;
    logic [2:0]  mag_bin;
    logic        mag_valid;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [15:0] drop_count;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Monitor state (written only by the monitor process)
    logic [11:0] last_adc = '0;
    int stream_cnt = 0, stream_bad = 0;
    int mag_cnt = 0, mag_bad = 0, mag_idx = 0;
    int fd_cnt = 0, overlap = 0;

    fft_frame_sequencer #(
        .FFT_LENGTH (N),
        .RST_CYCLES (4),
        .TIMEOUT    (100)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .adc_data          (adc_data),
        .adc_data_valid    (adc_data_valid),
        .done_FFT          (done_FFT),
        .magnitude         (magnitude),
        .magnitude_ready   (magnitude_ready),
        .fft_reset         (fft_reset),
        .fft_stream_active (fft_stream_active),
        .fft_input_real    (fft_input_real),
        .mag_out           (mag_out),
        .mag_bin           (mag_bin),
        .mag_valid         (mag_valid),
        .frame_done        (frame_done),
        .frame_count       (frame_count),
        .drop_count        (drop_count),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset_n) begin
            mag_idx = 0;
        end else begin
            if (fft_stream_active) begin
                stream_cnt++;
                if (fft_input_real !== {last_adc, 4'h0}) stream_bad++;
            end
            if (mag_valid) begin
                mag_cnt++;
                if (mag_idx >= HALF || mag_bin !== 3'(mag_idx) ||
                    mag_out !== 16'h1000 + 16'(mag_idx)) mag_bad++;
                mag_idx++;
            end
            if (frame_done) begin
                fd_cnt++;
                if (mag_valid) overlap++;
                if (mag_idx != HALF) mag_bad++;
                mag_idx = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_valid(input logic [11:0] d);
        adc_data = d;
        last_adc = d;
        adc_data_valid = 1'b1;
        @(negedge clk);
        adc_data_valid = 1'b0;
    endtask

    task automatic drop_pulse();
        adc_data = 12'hFFF;
        adc_data_valid = 1'b1;
        @(negedge clk);
        adc_data_valid = 1'b0;
    endtask

    task automatic load_frame(input int stop_at);
        for (int i = 0; i < N; i++) begin
            pulse_valid(12'h800 ^ 12'(i * 37));
            if (i == stop_at) enable = 1'b0;
            if (i != N - 1) @(negedge clk);
        end
    endtask

    task automatic done_pulse(input int gap);
        repeat (gap) @(negedge clk);
        done_FFT = 1'b1;
        @(negedge clk);
        done_FFT = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            magnitude = 16'h1000 + 16'(k);
            magnitude_ready = 1'b1;
            @(negedge clk);
            magnitude_ready = 1'b0;
            if (k % 5 == 4) @(negedge clk);
        end
    endtask

    task automatic wait_load();
        int w = 0;
        while (fft_reset !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("load_entry", fft_reset, 0);
    endtask

    initial begin
        int hi;
        int w;
        int fd0;
        int mc0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_fft_reset", fft_reset, 1);
        check("rst_stream", fft_stream_active, 0);
        check("rst_input_real", fft_input_real, 0);
        check("rst_mag_valid", mag_valid, 0);
        check("rst_mag_out", mag_out, 0);
        check("rst_mag_bin", mag_bin, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_timeout_err", timeout_err, 0);

        // Frame 1: core reset window with three drops inside it
        reset_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            adc_data_valid = 1'b0;
            if (fft_reset !== 1'b1) break;
            hi++;
            if (hi <= 3) begin
                adc_data = 12'h123;
                adc_data_valid = 1'b1;
            end
        end
        check("fft_reset_cycles", hi, 4);
        check("drops_in_reset", drop_count, 3);

        // done_FFT / magnitude_ready while loading are ignored
        done_FFT = 1'b1;
        magnitude_ready = 1'b1;
        @(negedge clk);
        done_FFT = 1'b0;
        magnitude_ready = 1'b0;
        @(negedge clk);

        load_frame(-1);
        drop_pulse();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drop_pulse();
        end
        magnitude_ready = 1'b1;
        @(negedge clk);
        magnitude_ready = 1'b0;
        check("drops_total_f1", drop_count, 8);
        done_pulse(3);
        #1;
        check("stream_count_f1", stream_cnt, N);
        check("stream_data_f1", stream_bad, 0);
        @(negedge clk);
        drain(N);
        check("frame_done_pulse", frame_done, 1);
        check("frame_count_f1", frame_count, 1);
        @(negedge clk);
        check("frame_done_single", frame_done, 0);
        #1;
        check("fd_cnt_f1", fd_cnt, 1);
        check("mag_count_f1", mag_cnt, HALF);
        check("mag_data_f1", mag_bad, 0);
        check("done_mag_overlap", overlap, 0);

        // Frame 2: done_FFT withheld -> timeout
        @(negedge clk);
        wait_load();
        load_frame(-1);
        w = 0;
        while (!timeout_err && w < 300) begin
            w++;
            @(negedge clk);
        end
        check("timeout_latency", w, 101);
        check("timeout_reenter_reset", fft_reset, 1);
        check("timeout_frame_count", frame_count, 1);
        #1;
        check("timeout_no_frame_done", fd_cnt, 1);

        // Frame 3: enable dropped mid-load
        @(negedge clk);
        wait_load();
        load_frame(5);
        done_pulse(10);
        drain(N);
        check("stop_frame_done", frame_done, 1);
        check("stop_frame_count", frame_count, 2);
        check("stop_to_idle_reset", fft_reset, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drop_pulse();
        end
        repeat (10) @(negedge clk);
        check("idle_fft_reset", fft_reset, 1);
        check("idle_drops", drop_count, 12);
        check("timeout_sticky", timeout_err, 1);
        #1;
        check("idle_no_stream", stream_cnt, 3 * N);
        check("mag_data_f3", mag_bad, 0);

        // Drop counter saturation
        @(negedge clk);
        adc_data_valid = 1'b1;
        repeat (65520) @(negedge clk);
        adc_data_valid = 1'b0;
        check("drop_near_sat", drop_count, 16'hFFFC);
        adc_data_valid = 1'b1;
        repeat (3) @(negedge clk);
        adc_data_valid = 1'b0;
        check("drop_sat", drop_count, 16'hFFFF);
        adc_data_valid = 1'b1;
        repeat (20) @(negedge clk);
        adc_data_valid = 1'b0;
        check("drop_no_wrap", drop_count, 16'hFFFF);

        // Reset during DRAIN at bin 5
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        wait_load();
        load_frame(-1);
        done_pulse(5);
        for (int k = 0; k < 5; k++) begin
            magnitude = 16'h1000 + 16'(k);
            magnitude_ready = 1'b1;
            @(negedge clk);
        end
        magnitude = 16'h1005;
        magnitude_ready = 1'b1;
        @(posedge clk);
        #2;
        magnitude_ready = 1'b0;
        check("pre_reset_mag_valid", mag_valid, 1);
        reset_n = 1'b0;
        #1;
        check("async_mag_valid", mag_valid, 0);
        check("async_fft_reset", fft_reset, 1);
        check("async_frame_count", frame_count, 0);
        check("async_drop_count", drop_count, 0);
        check("async_timeout_err", timeout_err, 0);
        check("async_mag_bin", mag_bin, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        fd0 = fd_cnt;
        mc0 = mag_cnt;
        @(negedge clk);
        wait_load();
        load_frame(-1);
        done_pulse(4);
        drain(N);
        check("post_reset_frame_done", frame_done, 1);
        check("post_reset_frame_count", frame_count, 1);
        @(negedge clk);
        enable = 1'b0;
        #1;
        check("post_reset_fd_cnt", fd_cnt - fd0, 1);
        check("post_reset_mag_cnt", mag_cnt - mc0, HALF);
        check("post_reset_mag_data", mag_bad, 0);
        check("post_reset_stream_data", stream_bad, 0);
        check("final_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
